// File: rtl/pkt_gen_pkg.sv
// Shared constants, FSM state type and LFSR step function for the packet burst generator.
package pkt_gen_pkg;

    localparam logic [1:0]  MODE_RAMP  = 2'd0;
    localparam logic [1:0]  MODE_LFSR  = 2'd1;
    localparam logic [1:0]  MODE_CONST = 2'd2;

    localparam logic [31:0] LFSR_SEED  = 32'h0000_0001;
    // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

    localparam logic [7:0]  CONST_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_SLEEP,
        ST_DONE
    } state_e;

    // One LFSR step; the all-zero lock-up state is replaced by the seed
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
        return (n == 32'd0) ? LFSR_SEED : n;
    endfunction

endpackage

// File: rtl/pkt_pattern_gen.sv
// Payload pattern source: owns ramp and LFSR state and formats them into lanes.
module pkt_pattern_gen
    import pkt_gen_pkg::*;
#(
    parameter int unsigned DOUT_WIDTH = 8,
    parameter int unsigned PARALLEL   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           advance,
    input  logic                           clear,
    input  logic [1:0]                     mode,
    output logic [DOUT_WIDTH*PARALLEL-1:0] beat_c
);

    localparam logic [DOUT_WIDTH-1:0] CONST_LANE =
        DOUT_WIDTH'({(DOUT_WIDTH / 8 + 1){CONST_BYTE}});

    logic [DOUT_WIDTH-1:0] ramp_q, ramp_d;
    logic [31:0]           lfsr_q, lfsr_d;

    // Only the pattern currently selected moves forward on a payload beat
    always_comb begin
        ramp_d = ramp_q;
        lfsr_d = lfsr_q;
        if (clear) begin
            ramp_d = '0;
        end else if (advance) begin
            case (mode)
                MODE_LFSR:  lfsr_d = lfsr_step(lfsr_q);
                MODE_CONST: begin end
                default:    ramp_d = ramp_q + DOUT_WIDTH'(PARALLEL);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_q <= '0;
            lfsr_q <= LFSR_SEED;
        end else begin
            ramp_q <= ramp_d;
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        beat_c = '0;
        for (int i = 0; i < int'(PARALLEL); i++) begin
            case (mode)
                MODE_LFSR:  beat_c[i*DOUT_WIDTH +: DOUT_WIDTH] = DOUT_WIDTH'(lfsr_q) ^ DOUT_WIDTH'(i);
                MODE_CONST: beat_c[i*DOUT_WIDTH +: DOUT_WIDTH] = CONST_LANE;
                default:    beat_c[i*DOUT_WIDTH +: DOUT_WIDTH] = ramp_q + DOUT_WIDTH'(i);
            endcase
        end
    end

endmodule

// File: rtl/pkt_burst_gen.sv
// Framed test-packet burst generator: FSM, packet/sequence counters, header mux and output registers.
module pkt_burst_gen
    import pkt_gen_pkg::*;
#(
    parameter int unsigned DOUT_WIDTH = 8,
    parameter int unsigned PARALLEL   = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [1:0]                     mode,
    input  logic                           hdr_en,
    input  logic [CNT_WIDTH-1:0]           burst_len,
    input  logic [CNT_WIDTH-1:0]           sleep_write,
    input  logic [CNT_WIDTH-1:0]           n_packets,
    output logic [DOUT_WIDTH*PARALLEL-1:0] dout,
    output logic                           dout_valid,
    output logic                           dout_sof,
    output logic                           dout_eof,
    output logic [CNT_WIDTH-1:0]           pkt_count,
    output logic                           done
);

    localparam int unsigned          W   = DOUT_WIDTH * PARALLEL;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [1:0]           mode_q;
    logic                 hdr_en_q;
    logic [CNT_WIDTH-1:0] len_q, sleep_q, npkt_q;
    logic [CNT_WIDTH-1:0] beat_q, beat_d, slp_cnt_q, slp_cnt_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d, seq_q, seq_d;
    logic [W-1:0]         dout_q, dout_d, pattern_c, hdr_c;
    logic                 valid_q, valid_d, sof_q, sof_d, eof_q, eof_d, done_q, done_d;
    logic                 latch_c, last_c, hdr_beat_c, advance_c, clear_c;

    // A length of 0 or 1 makes every beat the last one
    assign last_c = (len_q <= ONE) || (beat_q == len_q - ONE);
    assign hdr_c  = W'({32'(len_q), 32'(seq_q)});

    pkt_pattern_gen #(
        .DOUT_WIDTH (DOUT_WIDTH),
        .PARALLEL   (PARALLEL)
    ) u_pattern (
        .clk     (clk),
        .rst     (rst),
        .advance (advance_c),
        .clear   (clear_c),
        .mode    (mode_q),
        .beat_c  (pattern_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state; latch_c marks every edge that begins a new packet
    always_comb begin
        state_d = state_q;
        latch_c = 1'b0;
        case (state_q)
            ST_IDLE: if (en) begin
                state_d = ST_SEND;
                latch_c = 1'b1;
            end
            ST_SEND: if (last_c) begin
                if ((npkt_q != '0) && (pkt_cnt_q + ONE == npkt_q)) state_d = ST_DONE;
                else if (!en)                                      state_d = ST_IDLE;
                else if (sleep_q == '0) begin
                    state_d = ST_SEND;
                    latch_c = 1'b1;
                end else                                           state_d = ST_SLEEP;
            end
            ST_SLEEP: if (slp_cnt_q == sleep_q - ONE) begin
                state_d = en ? ST_SEND : ST_IDLE;
                latch_c = en;
            end
            ST_DONE: if (!en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        beat_d     = beat_q;
        slp_cnt_d  = slp_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        seq_d      = seq_q;
        dout_d     = '0;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        done_d     = 1'b0;
        hdr_beat_c = 1'b0;
        advance_c  = 1'b0;
        clear_c    = 1'b0;
        case (state_q)
            ST_SEND: begin
                hdr_beat_c = hdr_en_q && (beat_q == '0);
                valid_d    = 1'b1;
                sof_d      = (beat_q == '0);
                eof_d      = last_c;
                dout_d     = hdr_beat_c ? hdr_c : pattern_c;
                advance_c  = !hdr_beat_c;
                slp_cnt_d  = '0;
                if (last_c) begin
                    beat_d    = '0;
                    pkt_cnt_d = pkt_cnt_q + ONE;
                    seq_d     = seq_q + ONE;
                end else begin
                    beat_d    = beat_q + ONE;
                end
            end
            ST_SLEEP: slp_cnt_d = slp_cnt_q + ONE;
            ST_DONE: begin
                done_d = en;
                if (!en) begin
                    clear_c   = 1'b1;
                    pkt_cnt_d = '0;
                    seq_d     = '0;
                end
            end
            default: begin end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_RAMP;
            hdr_en_q <= 1'b0;
            len_q    <= '0;
            sleep_q  <= '0;
            npkt_q   <= '0;
        end else if (latch_c) begin
            mode_q   <= (mode == 2'd3) ? MODE_RAMP : mode;
            hdr_en_q <= hdr_en;
            len_q    <= burst_len;
            sleep_q  <= sleep_write;
            npkt_q   <= n_packets;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q    <= '0;
            slp_cnt_q <= '0;
            pkt_cnt_q <= '0;
            seq_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            beat_q    <= beat_d;
            slp_cnt_q <= slp_cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            seq_q     <= seq_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            done_q    <= done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_sof   = sof_q;
    assign dout_eof   = eof_q;
    assign pkt_count  = pkt_cnt_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pkt_burst_gen.sv
// Bench for pkt_burst_gen: directed scenarios plus randomized configs against a packet-level model.
module tb_pkt_burst_gen;

    localparam int unsigned DW  = 8;
    localparam int unsigned PAR = 16;
    localparam int unsigned CW  = 32;
    localparam int unsigned W   = DW * PAR;

    logic          clk = 1'b0;
    logic          rst, en, hdr_en;
    logic [1:0]    mode;
    logic [CW-1:0] burst_len, sleep_write, n_packets;
    logic [W-1:0]  dout;
    logic          dout_valid, dout_sof, dout_eof, done;
    logic [CW-1:0] pkt_count;

    int          checks = 0;
    int          errors = 0;
    int unsigned m_ramp;
    logic [31:0] m_lfsr;

    pkt_burst_gen #(.DOUT_WIDTH(DW), .PARALLEL(PAR), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .hdr_en(hdr_en),
        .burst_len(burst_len), .sleep_write(sleep_write), .n_packets(n_packets),
        .dout(dout), .dout_valid(dout_valid), .dout_sof(dout_sof), .dout_eof(dout_eof),
        .pkt_count(pkt_count), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int m, input bit h, input int len, input int slp, input int np);
        mode        = 2'(m);
        hdr_en      = h;
        burst_len   = CW'(len);
        sleep_write = CW'(slp);
        n_packets   = CW'(np);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        m_ramp = 0;
        m_lfsr = 32'h1;
    endtask

    // Reference LFSR built from the polynomial's exponent list
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        int          exps[4] = '{32, 22, 2, 1};
        logic [31:0] mask    = '0;
        foreach (exps[k]) mask[exps[k]-1] = 1'b1;
        return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
    endfunction

    function automatic logic [W-1:0] hdr_word(input int unsigned seq, input int unsigned len);
        logic [W-1:0] r;
        r        = '0;
        r[31:0]  = seq;
        r[63:32] = len;
        return r;
    endfunction

    // Expected next payload beat; steps the model pattern state
    function automatic logic [W-1:0] next_payload(input int m);
        logic [W-1:0] r;
        for (int i = 0; i < int'(PAR); i++) begin
            if (m == 1)      r[i*DW +: DW] = m_lfsr[DW-1:0] ^ DW'(i);
            else if (m == 2) r[i*DW +: DW] = 8'hA5;
            else             r[i*DW +: DW] = DW'((m_ramp + i) % 256);
        end
        if (m == 1)      m_lfsr = lfsr_next(m_lfsr);
        else if (m != 2) m_ramp = (m_ramp + PAR) % 256;
        return r;
    endfunction

    task automatic test_reset();
        set_cfg(0, 0, 4, 2, 3);
        do_reset();
        checks++;
        if ({dout_valid, dout_sof, dout_eof, done} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctl got %b exp 0000", {dout_valid, dout_sof, dout_eof, done});
        end
        checks++;
        if (dout !== '0 || pkt_count !== '0) begin
            errors++; $display("FAIL reset_data dout=%h cnt=%0d exp 0/0", dout, pkt_count);
        end
        tick(); tick();
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++; $display("FAIL idle_no_en valid=%b exp 0", dout_valid);
        end
    endtask

    task automatic test_ramp_burst();
        logic [W-1:0] exp;
        set_cfg(0, 0, 4, 2, 3);
        do_reset();
        en = 1'b1;
        tick();
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                tick();
                exp = next_payload(0);
                checks++;
                if ({dout_valid, dout_sof, dout_eof} !== {1'b1, b == 0, b == 3}) begin
                    errors++; $display("FAIL ramp_ctl p=%0d b=%0d got %b", p, b, {dout_valid, dout_sof, dout_eof});
                end
                checks++;
                if (dout !== exp) begin
                    errors++; $display("FAIL ramp_data p=%0d b=%0d got %h exp %h", p, b, dout, exp);
                end
                checks++;
                if (done !== 1'b0 || pkt_count !== CW'((b == 3) ? p + 1 : p)) begin
                    errors++; $display("FAIL ramp_cnt p=%0d b=%0d done=%b cnt=%0d", p, b, done, pkt_count);
                end
                if (p == 0 && b == 0) begin
                    checks++;
                    if (dout[7:0] !== 8'h00 || dout[127:120] !== 8'h0F) begin
                        errors++; $display("FAIL ramp_first got l0=%h l15=%h exp 00/0f", dout[7:0], dout[127:120]);
                    end
                end
                if (p == 0 && b == 3) begin
                    checks++;
                    if (dout[7:0] !== 8'h30) begin
                        errors++; $display("FAIL ramp_last got l0=%h exp 30", dout[7:0]);
                    end
                end
            end
            if (p < 2) begin
                for (int s = 0; s < 2; s++) begin
                    tick();
                    checks++;
                    if (dout_valid !== 1'b0 || dout !== '0) begin
                        errors++; $display("FAIL ramp_gap p=%0d s=%0d valid=%b dout=%h", p, s, dout_valid, dout);
                    end
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (done !== 1'b1 || pkt_count !== CW'(3) || dout_valid !== 1'b0) begin
                errors++; $display("FAIL ramp_done k=%0d done=%b cnt=%0d valid=%b exp 1/3/0", k, done, pkt_count, dout_valid);
            end
        end
        en = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || pkt_count !== '0) begin
            errors++; $display("FAIL done_exit done=%b cnt=%0d exp 0/0", done, pkt_count);
        end
        en = 1'b1;
        tick(); tick();
        checks++;
        if (dout_valid !== 1'b1 || dout[7:0] !== 8'h00) begin
            errors++; $display("FAIL rerun_ramp valid=%b l0=%h exp 1/00", dout_valid, dout[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp;
        set_cfg(2, 1, 3, 0, 0);
        do_reset();
        en = 1'b1;
        tick();
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 3; b++) begin
                tick();
                exp = (b == 0) ? hdr_word(p, 3) : next_payload(2);
                checks++;
                if ({dout_valid, dout_sof, dout_eof} !== {1'b1, b == 0, b == 2}) begin
                    errors++; $display("FAIL b2b_ctl p=%0d b=%0d got %b", p, b, {dout_valid, dout_sof, dout_eof});
                end
                checks++;
                if (dout !== exp) begin
                    errors++; $display("FAIL b2b_data p=%0d b=%0d got %h exp %h", p, b, dout, exp);
                end
                if (p == 3 && b == 1) en = 1'b0;
            end
        end
        tick();
        checks++;
        if (dout_valid !== 1'b0 || dout !== '0 || done !== 1'b0 || pkt_count !== CW'(4)) begin
            errors++; $display("FAIL b2b_stop valid=%b done=%b cnt=%0d exp 0/0/4", dout_valid, done, pkt_count);
        end
    endtask

    task automatic test_single_beat();
        logic [W-1:0] exp;
        for (int len = 0; len < 2; len++) begin
            set_cfg(0, 0, len, 1, 2);
            do_reset();
            en = 1'b1;
            tick();
            for (int p = 0; p < 2; p++) begin
                tick();
                exp = next_payload(0);
                checks++;
                if ({dout_valid, dout_sof, dout_eof} !== 3'b111 || dout !== exp) begin
                    errors++; $display("FAIL single len=%0d p=%0d ctl=%b dout=%h exp 111 %h", len, p, {dout_valid, dout_sof, dout_eof}, dout, exp);
                end
                if (p == 0) begin
                    tick();
                    checks++;
                    if (dout_valid !== 1'b0) begin
                        errors++; $display("FAIL single_gap len=%0d valid=%b exp 0", len, dout_valid);
                    end
                end
            end
            tick();
            checks++;
            if (done !== 1'b1 || pkt_count !== CW'(2)) begin
                errors++; $display("FAIL single_done len=%0d done=%b cnt=%0d exp 1/2", len, done, pkt_count);
            end
        end
    endtask

    task automatic test_lfsr();
        logic [W-1:0] exp;
        set_cfg(1, 0, 8, 1, 2);
        do_reset();
        en = 1'b1;
        tick();
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 8; b++) begin
                tick();
                exp = next_payload(1);
                checks++;
                if ({dout_valid, dout_sof, dout_eof} !== {1'b1, b == 0, b == 7} || dout !== exp) begin
                    errors++; $display("FAIL lfsr p=%0d b=%0d ctl=%b got %h exp %h", p, b, {dout_valid, dout_sof, dout_eof}, dout, exp);
                end
                checks++;
                if (dout === '0) begin
                    errors++; $display("FAIL lfsr_zero p=%0d b=%0d got 0 exp nonzero", p, b);
                end
                if (p == 0 && b == 0) begin
                    checks++;
                    if (dout[7:0] !== 8'h01 || dout[15:8] !== 8'h00) begin
                        errors++; $display("FAIL lfsr_seed got l0=%h l1=%h exp 01/00", dout[7:0], dout[15:8]);
                    end
                end
            end
            if (p == 0) tick();
        end
    endtask

    task automatic test_en_drop();
        logic [W-1:0] exp;
        set_cfg(0, 0, 8, 0, 0);
        do_reset();
        en = 1'b1;
        tick();
        for (int b = 0; b < 8; b++) begin
            tick();
            exp = next_payload(0);
            checks++;
            if ({dout_valid, dout_sof, dout_eof} !== {1'b1, b == 0, b == 7} || dout !== exp) begin
                errors++; $display("FAIL endrop_beat b=%0d ctl=%b got %h exp %h", b, {dout_valid, dout_sof, dout_eof}, dout, exp);
            end
            if (b == 2) en = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (dout_valid !== 1'b0 || dout !== '0 || pkt_count !== CW'(1)) begin
                errors++; $display("FAIL endrop_idle k=%0d valid=%b cnt=%0d exp 0/1", k, dout_valid, pkt_count);
            end
        end
        en = 1'b1;
        tick(); tick();
        exp = next_payload(0);
        checks++;
        if (dout_sof !== 1'b1 || dout !== exp) begin
            errors++; $display("FAIL endrop_resume sof=%b got %h exp %h", dout_sof, dout, exp);
        end
    endtask

    task automatic test_rst_mid_packet();
        logic [W-1:0] exp;
        set_cfg(0, 1, 8, 0, 0);
        do_reset();
        en = 1'b1;
        tick();
        for (int n = 0; n < 11; n++) begin
            tick();
            exp = (n == 0 || n == 8) ? hdr_word(n / 8, 8) : next_payload(0);
            checks++;
            if (dout !== exp) begin
                errors++; $display("FAIL prerst n=%0d got %h exp %h", n, dout, exp);
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({dout_valid, dout_sof, dout_eof} !== 3'b000 || dout !== '0 || pkt_count !== '0) begin
            errors++; $display("FAIL rst_mid ctl=%b dout=%h cnt=%0d exp 000/0/0", {dout_valid, dout_sof, dout_eof}, dout, pkt_count);
        end
        rst    = 1'b0;
        m_ramp = 0;
        m_lfsr = 32'h1;
        tick(); tick();
        checks++;
        if (dout_sof !== 1'b1 || dout !== hdr_word(0, 8)) begin
            errors++; $display("FAIL rst_restart_hdr sof=%b got %h", dout_sof, dout);
        end
        tick();
        exp = next_payload(0);
        checks++;
        if (dout !== exp) begin
            errors++; $display("FAIL rst_restart_ramp got %h exp %h", dout, exp);
        end
    endtask

    task automatic drive_cfg(input bit garbage, input int m, input bit h, input int len, input int slp, input int np);
        if (garbage) begin
            mode        = 2'($urandom_range(0, 3));
            hdr_en      = 1'($urandom_range(0, 1));
            burst_len   = CW'($urandom_range(0, 9));
            sleep_write = CW'($urandom_range(0, 5));
            n_packets   = CW'($urandom_range(0, 5));
        end else begin
            set_cfg(m, h, len, slp, np);
        end
    endtask

    // Config inputs are scrambled except on the edges that start a packet
    task automatic test_random();
        logic [W-1:0] exp;
        int m, len, slp, np, eff;
        bit h, latch;
        for (int it = 0; it < 10; it++) begin
            m   = $urandom_range(0, 3);
            h   = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 6);
            slp = $urandom_range(0, 3);
            np  = $urandom_range(1, 3);
            eff = (len == 0) ? 1 : len;
            set_cfg(m, h, len, slp, np);
            do_reset();
            en = 1'b1;
            tick();
            for (int p = 0; p < np; p++) begin
                for (int b = 0; b < eff; b++) begin
                    latch = (b == eff - 1) && (slp == 0) && (p < np - 1);
                    drive_cfg(!latch, m, h, len, slp, np);
                    tick();
                    exp = (h && b == 0) ? hdr_word(p, len) : next_payload(m);
                    checks++;
                    if ({dout_valid, dout_sof, dout_eof} !== {1'b1, b == 0, b == eff - 1} || dout !== exp) begin
                        errors++; $display("FAIL rand it=%0d p=%0d b=%0d ctl=%b got %h exp %h", it, p, b, {dout_valid, dout_sof, dout_eof}, dout, exp);
                    end
                end
                if (p < np - 1) begin
                    for (int s = 0; s < slp; s++) begin
                        drive_cfg(s != slp - 1, m, h, len, slp, np);
                        tick();
                        checks++;
                        if (dout_valid !== 1'b0 || dout !== '0) begin
                            errors++; $display("FAIL rand_gap it=%0d p=%0d s=%0d valid=%b", it, p, s, dout_valid);
                        end
                    end
                end
            end
            drive_cfg(1'b1, m, h, len, slp, np);
            tick();
            checks++;
            if (done !== 1'b1 || pkt_count !== CW'(np) || dout_valid !== 1'b0) begin
                errors++; $display("FAIL rand_done it=%0d done=%b cnt=%0d exp 1/%0d", it, done, pkt_count, np);
            end
            en = 1'b0;
            tick();
            checks++;
            if (done !== 1'b0 || pkt_count !== '0) begin
                errors++; $display("FAIL rand_exit it=%0d done=%b cnt=%0d exp 0/0", it, done, pkt_count);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        set_cfg(0, 0, 1, 0, 0);
        test_reset();
        test_ramp_burst();
        test_back_to_back();
        test_single_beat();
        test_lfsr();
        test_en_drop();
        test_rst_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_burst_gen.md
Name: pkt_burst_gen

Overview:
Parametrised successor to the fixed 8x16 packet generator: emits framed test packets of burst_len beats, separated by sleep_write idle cycles, across PARALLEL lanes of DOUT_WIDTH bits.
Adds:
- selectable payload pattern;
- sequence-number header beat;
- start/end-of-frame strobes;
- a finite packet count with a done indication.
Sits upstream of the 1GbE/10GbE packetiser as a link and throughput stimulus source.

Parameters:
DOUT_WIDTH, 8, bits per lane
PARALLEL, 16, lanes per beat; DOUT_WIDTH*PARALLEL must be >= 32
CNT_WIDTH, 32, width of burst_len, sleep_write, n_packets and the counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  run enable, level-sensitive
mode  in  2  payload pattern: 0 ramp, 1 LFSR, 2 constant 0xA5 per byte, 3 treated as 0
hdr_en  in  1  when 1, the first beat of each packet is a header
burst_len  in  CNT_WIDTH  beats per packet including header; 0 treated as 1
sleep_write  in  CNT_WIDTH  idle cycles between packets
n_packets  in  CNT_WIDTH  packets per run; 0 = unlimited
dout  out  DOUT_WIDTH*PARALLEL  beat data; lane i = bits [i*DOUT_WIDTH +: DOUT_WIDTH]
dout_valid  out  1  beat valid
dout_sof  out  1  first beat of packet, qualified by dout_valid
dout_eof  out  1  last beat of packet, qualified by dout_valid
pkt_count  out  CNT_WIDTH  packets completed in this run
done  out  1  high while in DONE

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous and active-high. All outputs are registered.
- Reset values: dout=0, valid/sof/eof=0, pkt_count=0, done=0, FSM=IDLE, LFSR=32'h0000_0001, seq=0, ramp=0.
- FSM states: IDLE, SEND, SLEEP, DONE.
- IDLE:
  - en=1 latches mode, hdr_en, burst_len, sleep_write and n_packets, then goes to SEND.
  - The first beat appears on the next cycle after en is sampled high.
- SEND:
  - One beat per cycle; beat counter runs 0..burst_len-1.
  - sof on beat 0; eof on the last beat. burst_len<=1 gives sof=eof=1 on the same beat.
  - On eof:
    - pkt_count increments and seq increments.
    - If n_packets!=0 and pkt_count+1==n_packets, go to DONE.
    - Else if en=0, go to IDLE.
    - Else if sleep_write==0, go to SEND; the next sof is on the next cycle with no gap.
    - Else go to SLEEP.
- SLEEP:
  - dout_valid=0 for exactly sleep_write cycles.
  - Then go to SEND if en=1, else IDLE.
  - Config is re-latched at each packet start.
- DONE:
  - done=1 and valid=0.
  - Stays in DONE while en=1. en=0 goes to IDLE and clears pkt_count, seq, ramp and done.
- en deasserted mid-packet: the current packet completes; packets are never truncated. Only rst aborts a packet.
- Header beat (hdr_en=1, beat 0):
  - bits [31:0] = seq, bits [63:32] = burst_len (if width permits), remaining bits 0.
  - Payload pattern state does not advance on the header beat.
- Payload patterns:
  - Ramp (mode 0): lane i = (ramp + i) mod 2^DOUT_WIDTH; ramp += PARALLEL per payload beat. Ramp wraps silently and continues across packets.
  - LFSR (mode 1): 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advanced once per payload beat. lane i = lfsr[DOUT_WIDTH-1:0] XOR i (i truncated to DOUT_WIDTH). The LFSR is never allowed to reach 0.
  - Constant (mode 2): every byte 0xA5, replicated to fill each lane.
- Counter wrap: pkt_count and seq wrap at 2^CNT_WIDTH without a flag.
- Idle outputs: when dout_valid=0, dout holds 0.
- Input changes to mode, hdr_en, burst_len, sleep_write or n_packets mid-packet have no effect until the next packet start.

Decomposition:
- Package pkt_gen_pkg:
  - mode constants MODE_RAMP=0, MODE_LFSR=1, MODE_CONST=2;
  - LFSR_SEED=32'h1 and the LFSR polynomial tap mask;
  - FSM state enum;
  - CONST_BYTE=8'hA5.
- Sub-module pkt_pattern_gen:
  - owns the ramp and LFSR state and the lane formatting;
  - inputs: clk, rst, advance, clear, mode;
  - output: the payload beat.
- The top module holds the FSM, counters, header mux and output registers.

Test Plan:
- Parameters 8x16. Config: mode=0, hdr_en=0, burst_len=4, sleep_write=2, n_packets=3, en held high.
  - Expected: three 4-beat packets, each followed by 2 invalid cycles.
  - First beat lane0=0x00, lane15=0x0F; last beat lane0=0x30.
  - done rises the cycle after the 3rd eof; pkt_count=3.
- Config: hdr_en=1, burst_len=3, sleep_write=0, mode=2, n_packets=0.
  - Expected: back-to-back packets, no gap between eof and sof.
  - Header beats carry seq 0,1,2 in [31:0] and 3 in [63:32].
  - Payload beats are all 0xA5.
- Config: burst_len=0 and burst_len=1.
  - Expected: single-beat packets with sof=eof=dout_valid=1.
- Config: mode=1, burst_len=8.
  - Expected: the payload LFSR sequence matches the reference model from seed 1 and never reads 0.
- Stimulus: en dropped at beat 2 of an 8-beat packet.
  - Expected: beats 3..7 still emitted, eof is seen, then IDLE with valid=0.
- Stimulus: rst asserted mid-packet.
  - Expected: the next cycle has dout_valid=0, dout=0, pkt_count=0. A subsequent run restarts at ramp 0 and seq 0.
